// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: NBITS data bits, TICKS oversample ticks per bit, 1 or 2 stop bits.
// Build with UART_TX_PARITY_EN to add the per-frame i_parity select and the PARITY bit.
module uart_tx_cfg #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_baud_rate,
  input  logic             i_tx_start,
  input  logic [NBITS-1:0] i_data,
  input  logic             i_stop2,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]       i_parity,
`endif
  output logic             o_tx_done,
  output logic             o_tx
);

  localparam int unsigned TW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int unsigned BW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  state_e           state_q;
  logic [TW-1:0]    tick_q;
  logic [BW-1:0]    bit_q;
  logic [NBITS-1:0] data_q;
  logic             stop2_q;
  logic             tx_q;
  logic             done_q;
`ifdef UART_TX_PARITY_EN
  logic             par_en_q;
  logic             par_bit_q;
`endif

  assign o_tx      = tx_q;
  assign o_tx_done = done_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      done_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else if (state_q == IDLE) begin
      tx_q   <= 1'b1;
      done_q <= 1'b1;
      if (i_tx_start) begin
        data_q    <= i_data;
        stop2_q   <= i_stop2;
`ifdef UART_TX_PARITY_EN
        // Parity is taken from the value latched here, so the shifting copy is not needed later.
        par_en_q  <= (i_parity == 2'b01) || (i_parity == 2'b10);
        par_bit_q <= (^i_data) ^ (i_parity == 2'b10);
`endif
        tick_q    <= '0;
        bit_q     <= '0;
        state_q   <= START;
        tx_q      <= 1'b0;
        done_q    <= 1'b0;
      end
    end else if (i_baud_rate) begin
      if (tick_q != TW'(TICKS - 1)) begin
        tick_q <= tick_q + TW'(1);
      end else begin
        tick_q <= '0;
        case (state_q)
          START: begin
            state_q <= DATA;
            tx_q    <= data_q[0];
            data_q  <= data_q >> 1;
            bit_q   <= BW'(1);
          end
          DATA: begin
            if (bit_q < BW'(NBITS)) begin
              tx_q   <= data_q[0];
              data_q <= data_q >> 1;
              bit_q  <= bit_q + BW'(1);
            end
`ifdef UART_TX_PARITY_EN
            else if (par_en_q) begin
              state_q <= PARITY;
              tx_q    <= par_bit_q;
            end
`endif
            else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
              bit_q   <= '0;
            end
          end
          PARITY: begin
            state_q <= STOP;
            tx_q    <= 1'b1;
            bit_q   <= '0;
          end
          STOP: begin
            // bit_q counts completed stop bits; a second one is only owed with stop2.
            if (stop2_q && (bit_q == '0)) begin
              bit_q <= BW'(1);
            end else begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              bit_q   <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: 8-bit/16-tick and 5-bit/8-tick instances vs a frame-level model.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        baud = 1'b0;
  logic        start8 = 1'b0;
  logic        start5 = 1'b0;
  logic        stop2 = 1'b0;
  logic [15:0] data = '0;
  logic [1:0]  par = 2'b00;
  logic        tx8, done8, tx5, done5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_tx_cfg #(.NBITS(8), .TICKS(16)) dut8 (
    .clk(clk), .rst(rst), .i_baud_rate(baud), .i_tx_start(start8),
    .i_data(data[7:0]), .i_stop2(stop2),
`ifdef UART_TX_PARITY_EN
    .i_parity(par),
`endif
    .o_tx_done(done8), .o_tx(tx8));

  uart_tx_cfg #(.NBITS(5), .TICKS(8)) dut5 (
    .clk(clk), .rst(rst), .i_baud_rate(baud), .i_tx_start(start5),
    .i_data(data[4:0]), .i_stop2(stop2),
`ifdef UART_TX_PARITY_EN
    .i_parity(par),
`endif
    .o_tx_done(done5), .o_tx(tx5));

  // Entered at a negedge with the selected DUT idle. bperiod: 0 = random ticks, N = tick every Nth clk.
  // rst_at >= 0 pulls reset for the edge after that cycle and ends the frame there.
  task automatic send(input int sel, input logic [15:0] d, input bit s2, input bit [1:0] p,
                      input int bperiod, input bit noisy, input int rst_at);
    int  T, nb, total, ticks, cyc, ones;
    bit  bits[$];
    bit  cur_baud, rst_edge, exp_tx, exp_done, otx, odone;
    logic [15:0] dm;
    T  = sel ? 8 : 16;
    nb = sel ? 5 : 8;
    dm = d & ((16'd1 << nb) - 16'd1);
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) bits.push_back(dm[i]);
    ones = $countones(dm);
`ifdef UART_TX_PARITY_EN
    if (p == 2'b01) bits.push_back(ones % 2 == 1);
    if (p == 2'b10) bits.push_back(ones % 2 == 0);
`endif
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    total = T * bits.size();

    data = d; stop2 = s2; par = p;
    if (sel) start5 = 1'b1; else start8 = 1'b1;
    cur_baud = (bperiod == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    baud = cur_baud;
    cyc = 0; ticks = 0; rst_edge = 1'b0;
    forever begin
      @(negedge clk);
      otx   = sel ? tx5 : tx8;
      odone = sel ? done5 : done8;
      if (rst_edge) begin
        checks++;
        if (otx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx sel=%0d got=%b want=1", sel, otx); end
        checks++;
        if (odone !== 1'b1) begin errors++; $display("FAIL reset_mid_done sel=%0d got=%b want=1", sel, odone); end
        rst = 1'b1;
        break;
      end
      if (cyc > 0 && cur_baud) ticks++;
      exp_done = (ticks == total);
      exp_tx   = exp_done ? 1'b1 : bits[ticks / T];
      checks++;
      if (otx !== exp_tx) begin
        errors++; $display("FAIL tx sel=%0d data=%h cyc=%0d got=%b want=%b", sel, d, cyc, otx, exp_tx);
      end
      checks++;
      if (odone !== exp_done) begin
        errors++; $display("FAIL done sel=%0d data=%h cyc=%0d got=%b want=%b", sel, d, cyc, odone, exp_done);
      end
      if (exp_done) break;
      if (cyc > 6000) begin
        errors++; $display("FAIL timeout sel=%0d data=%h got=busy want=done", sel, d);
        break;
      end
      cyc++;
      if (noisy) begin
        data = 16'($urandom);
        stop2 = 1'($urandom);
        par = 2'($urandom);
      end
      if (sel) start5 = noisy ? 1'($urandom) : 1'b0;
      else     start8 = noisy ? 1'($urandom) : 1'b0;
      cur_baud = (bperiod == 0) ? 1'($urandom_range(0, 1)) : (cyc % bperiod == 0);
      baud = cur_baud;
      if (cyc == rst_at) begin rst = 1'b0; rst_edge = 1'b1; end
    end
    start8 = 1'b0; start5 = 1'b0; baud = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx8 !== 1'b1)   begin errors++; $display("FAIL reset_tx8 got=%b want=1", tx8); end
    checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL reset_done8 got=%b want=1", done8); end
    checks++; if (tx5 !== 1'b1)   begin errors++; $display("FAIL reset_tx5 got=%b want=1", tx5); end
    checks++; if (done5 !== 1'b1) begin errors++; $display("FAIL reset_done5 got=%b want=1", done5); end
    rst = 1'b1; baud = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (tx8 !== 1'b1 || done8 !== 1'b1) begin
      errors++; $display("FAIL idle_ignores_baud got=%b%b want=11", tx8, done8);
    end
    baud = 1'b0;
  endtask

  task automatic test_basic();
    send(0, 16'h00A5, 1'b0, 2'b00, 1, 1'b0, -1);
    send(0, 16'h005A, 1'b0, 2'b11, 1, 1'b0, -1);
  endtask

  task automatic test_parity();
    send(0, 16'h0007, 1'b0, 2'b01, 1, 1'b0, -1);
    send(0, 16'h0007, 1'b0, 2'b10, 1, 1'b0, -1);
    send(0, 16'h0000, 1'b0, 2'b01, 1, 1'b0, -1);
    send(1, 16'h0013, 1'b1, 2'b10, 1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    send(0, 16'h00FF, 1'b1, 2'b00, 1, 1'b0, -1);
    send(0, 16'h0081, 1'b0, 2'b00, 1, 1'b0, -1);
  endtask

  task automatic test_slow_baud();
    send(0, 16'h00C3, 1'b0, 2'b00, 4, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    send(0, 16'h003C, 1'b0, 2'b00, 1, 1'b0, 50);
    send(0, 16'h003C, 1'b0, 2'b00, 1, 1'b0, -1);
  endtask

  task automatic test_small();
    send(1, 16'h0013, 1'b0, 2'b00, 1, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++)
      send(int'(i % 2), 16'($urandom), 1'($urandom), 2'($urandom), int'($urandom_range(0, 3)),
           1'($urandom), -1);
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_back_to_back();
    test_slow_baud();
    test_reset_mid();
    test_small();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter for the serial I/O path; replaces the fixed 8N1 transmitter.
- Data width and oversampling factor are compile-time parameters.
- Stop-bit count is selected per frame; parity is selected per frame when the optional feature is built.
- Driven by the shared baud-tick generator: one i_baud_rate pulse per oversample tick. Serialises one frame per i_tx_start, LSB first.

Parameters:
NBITS, 8, data bits per frame (5..16)
TICKS, 16, baud ticks per serial bit (2..64); tick counter width is clog2(TICKS)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-low
i_baud_rate  input  1  oversample tick, one-clk pulse; may be high every cycle
i_tx_start  input  1  frame request, sampled only in IDLE
i_data  input  NBITS  frame payload, latched on accepted start
i_stop2  input  1  0 = one stop bit, 1 = two stop bits; latched on accepted start
i_parity  input  2  00 none, 01 even, 10 odd, 11 none; latched on accepted start (present only with UART_TX_PARITY_EN)
o_tx_done  output  1  high when idle and ready to accept a frame
o_tx  output  1  serial line, idle high, registered

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, all counters 0, data shift register 0, latched config 0.
  - o_tx=1, o_tx_done=1.
  - Applies mid-frame as well: the line is high on the cycle after the reset edge. No partial frame resumes.
- All outputs are registered. o_tx changes only on clk edges.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - o_tx=1, o_tx_done=1; i_baud_rate is ignored.
  - On an edge with i_tx_start=1: latch i_data, i_stop2 and i_parity; clear tick and bit counters; state<=START; o_tx<=0; o_tx_done<=0.
  - Latency from start edge to line low: 1 clk.
- Tick counting in every non-IDLE state:
  - Each clk with i_baud_rate=1 increments tick_count.
  - When tick_count==TICKS-1 with i_baud_rate=1, that edge is the bit boundary: tick_count<=0.
  - Each serial bit therefore lasts exactly TICKS baud ticks, measured from the edge that drove it.
  - Cycles without a tick hold all state.
- START boundary: state<=DATA; o_tx<=data_reg[0]; data_reg shifts right by one; bit_count<=1.
- DATA boundary:
  - If bit_count<NBITS: o_tx<=data_reg[0], shift, bit_count+1.
  - If bit_count==NBITS: go to PARITY when parity is enabled and selected (o_tx<=computed parity bit); otherwise go to STOP with o_tx<=1.
- Parity bit:
  - Even: XOR of the latched data, so total ones including parity is even.
  - Odd: inverse of the even value.
  - Computed from the latched copy, not from the live i_data.
- PARITY boundary: state<=STOP; o_tx<=1.
- STOP: o_tx=1 for TICKS ticks (i_stop2=0) or 2*TICKS ticks (i_stop2=1). Stop-bit count is tracked in bit_count, reused.
- Final STOP boundary: state<=IDLE; o_tx_done<=1. A new i_tx_start is accepted on the next edge, giving back-to-back frames with no idle gap.
- i_tx_start while not in IDLE is ignored, with no queuing.
- i_data, i_stop2 and i_parity changes after the accepting edge do not affect the frame in flight.
- Frame length in ticks: TICKS*(1+NBITS+P+S), where P is 0 or 1 and S is 1 or 2.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: i_parity port and the PARITY state exist; behaviour as above.
- Undefined: i_parity port is absent, the PARITY state is never entered, and DATA goes directly to STOP. Frames are NBITS-N-1/2 only.

Test Plan:
- NBITS=8, TICKS=16, i_baud_rate=1 every cycle, i_data=0xA5, i_stop2=0, parity none:
  - o_tx=0 for 16 clk.
  - Then bits 1,0,1,0,0,1,0,1 at 16 clk each.
  - Then 1 for 16 clk; o_tx_done returns 1 exactly 160 clk after the start edge.
- UART_TX_PARITY_EN, i_data=0x07:
  - even parity gives parity bit=1 for 16 clk before stop.
  - odd parity gives 0.
  - 0x00 with even parity gives 0.
- i_stop2=1, i_data=0xFF: stop high lasts 32 clk; o_tx_done rises at 176 clk. Assert a second start on the done cycle; the next start bit begins with no idle gap.
- i_baud_rate pulsing every 4th clk, TICKS=16: every bit lasts 64 clk. i_tx_start pulses mid-frame are ignored, and i_data changes mid-frame do not alter the bits sent.
- Pull rst=0 for one edge during DATA of 0x3C: o_tx=1 and o_tx_done=1 the next cycle, state IDLE. A fresh frame of 0x3C then transmits correctly.
- NBITS=5, TICKS=8, data 0x13: frame of 1+5+1 bits at 8 ticks each (56 clk), LSB first 1,1,0,0,1.
